// File: rtl/mul_unit.sv
// Iterative shift-add multiply / multiply-accumulate producing low WIDTH bits and NZCV.
// Fixed latency WIDTH+1 edges from Start to Done; Busy stalls Execute, Start in RUN is ignored.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Accumulate,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] SrcC,
  input  logic [3:0]       FlagsIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       MulFlags
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] p_reg;
  logic [CW-1:0]    cnt;
  logic             c_flag;
  logic             v_flag;
  logic [WIDTH-1:0] p_next;

  // Partial product after this cycle's add; also feeds Result on the final iteration.
  always_comb begin
    p_next = p_reg;
    if (q_reg[0]) p_next = p_reg + m_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      m_reg    <= '0;
      q_reg    <= '0;
      p_reg    <= '0;
      cnt      <= '0;
      c_flag   <= 1'b0;
      v_flag   <= 1'b0;
      Result   <= '0;
      MulFlags <= 4'b0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            m_reg  <= SrcA;
            q_reg  <= SrcB;
            p_reg  <= Accumulate ? SrcC : '0;
            cnt    <= '0;
            c_flag <= FlagsIn[1];
            v_flag <= FlagsIn[0];
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p_reg <= p_next;
          m_reg <= m_reg << 1;
          q_reg <= q_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            Result   <= p_next;
            MulFlags <= {p_next[WIDTH-1], (p_next == '0), c_flag, v_flag};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: directed vectors plus random MUL/MLA against a plain-arithmetic model.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Accumulate;
  logic [31:0] SrcA, SrcB, SrcC;
  logic [3:0]  FlagsIn;
  logic        Busy, Done;
  logic [31:0] Result;
  logic [3:0]  MulFlags;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Accumulate(Accumulate),
    .SrcA(SrcA), .SrcB(SrcB), .SrcC(SrcC), .FlagsIn(FlagsIn),
    .Busy(Busy), .Done(Done), .Result(Result), .MulFlags(MulFlags)
  );

  // Reference: full 64-bit product, truncated, plus optional addend; flags {N,Z,C,V}.
  function automatic logic [35:0] model(input logic [31:0] a, b, c, input logic acc,
                                        input logic [3:0] f);
    logic [63:0] prod;
    logic [31:0] r;
    prod = 64'(a) * 64'(b);
    r    = prod[31:0] + (acc ? c : 32'd0);
    return {r[31], (r == 32'd0), f[1], f[0], r};
  endfunction

  task automatic start_op(input logic [31:0] a, b, c, input logic acc, input logic [3:0] f);
    SrcA = a; SrcB = b; SrcC = c; Accumulate = acc; FlagsIn = f; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; SrcC = $urandom;
    Accumulate = 1'($urandom); FlagsIn = 4'($urandom);
  endtask

  // Called #1 after the Start edge. lat counts edges including the Start edge.
  task automatic run_to_done(input int inject_at, output int lat, output int busy_n,
                             output logic held);
    logic [31:0] r0;
    r0 = Result; lat = -1; busy_n = 0; held = 1'b1;
    for (int j = 0; j < 100; j++) begin
      if (Done) begin
        lat = j + 1;
        break;
      end
      if (Busy) busy_n++;
      if (Result !== r0) held = 1'b0;
      if (j == inject_at) begin
        Start = 1'b1; Accumulate = 1'b1;
        SrcA = $urandom; SrcB = $urandom; SrcC = $urandom;
      end else begin
        Start = 1'b0;
      end
      @(posedge clk); #1;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; Start = 1'b0; Accumulate = 1'b0;
    SrcA = '0; SrcB = '0; SrcC = '0; FlagsIn = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({Busy, Done, Result, MulFlags} !== 38'd0)
      $display("FAIL reset_state got busy=%b done=%b res=%h flags=%b want all 0",
               Busy, Done, Result, MulFlags);
    else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, bn;
    logic held;
    start_op(32'd7, 32'd6, 32'd0, 1'b0, 4'b0011);
    run_to_done(-1, lat, bn, held);
    total++;
    if (lat !== 33) $display("FAIL basic_latency got %0d want 33", lat); else passed++;
    total++;
    if (bn !== 32) $display("FAIL basic_busy_cycles got %0d want 32", bn); else passed++;
    total++;
    if (held !== 1'b1) $display("FAIL basic_result_held got %b want 1", held); else passed++;
    total++;
    if (Result !== 32'd42) $display("FAIL basic_result got %h want 0000002a", Result);
    else passed++;
    total++;
    if (MulFlags !== 4'b0011) $display("FAIL basic_flags got %b want 0011", MulFlags);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0)
      $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", Done, Busy);
    else passed++;
  endtask

  logic [31:0] va [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'h00000000};
  logic [31:0] vb [4] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000002, 32'h12345678};
  logic [31:0] vc [4] = '{32'h00000000, 32'h00000001, 32'h00000000, 32'h00000005};
  logic        vacc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0]  vf [4] = '{4'b0000, 4'b0100, 4'b0100, 4'b1010};
  logic [31:0] vres [4] = '{32'h00000001, 32'h00000000, 32'h80000000, 32'h00000005};
  logic [3:0]  vflg [4] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010};

  task automatic test_directed;
    int lat, bn;
    logic held;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vc[i], vacc[i], vf[i]);
      run_to_done(-1, lat, bn, held);
      total++;
      if (Result !== vres[i] || MulFlags !== vflg[i] || lat !== 33)
        $display("FAIL directed_%0d got res=%h flags=%b lat=%0d want res=%h flags=%b lat=33",
                 i, Result, MulFlags, lat, vres[i], vflg[i]);
      else passed++;
    end
  endtask

  task automatic test_random;
    int lat, bn;
    logic held;
    logic [31:0] a, b, c;
    logic acc;
    logic [3:0] f;
    logic [35:0] exp;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; c = $urandom; acc = 1'($urandom); f = 4'($urandom);
      if (i == 0) b = 32'd0;
      if (i == 1) b = 32'h80000001;
      exp = model(a, b, c, acc, f);
      start_op(a, b, c, acc, f);
      run_to_done(-1, lat, bn, held);
      total++;
      if (Result !== exp[31:0] || MulFlags !== exp[35:32] || lat !== 33)
        $display("FAIL random_%0d got res=%h flags=%b lat=%0d want res=%h flags=%b lat=33",
                 i, Result, MulFlags, lat, exp[31:0], exp[35:32]);
      else passed++;
    end
  endtask

  task automatic test_start_ignored;
    int lat, bn;
    logic held;
    logic [35:0] exp;
    exp = model(32'h00012345, 32'h00000777, 32'h00000010, 1'b1, 4'b0001);
    start_op(32'h00012345, 32'h00000777, 32'h00000010, 1'b1, 4'b0001);
    run_to_done(4, lat, bn, held);
    total++;
    if (lat !== 33 || bn !== 32)
      $display("FAIL ignored_timing got lat=%0d busy=%0d want 33 32", lat, bn);
    else passed++;
    total++;
    if (Result !== exp[31:0] || MulFlags !== exp[35:32])
      $display("FAIL ignored_result got res=%h flags=%b want res=%h flags=%b",
               Result, MulFlags, exp[31:0], exp[35:32]);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL ignored_no_second_op got busy=%b done=%b want 0 0", Busy, Done);
    else passed++;
  endtask

  task automatic test_reset_abort;
    int lat, bn;
    logic held;
    int seen_done;
    logic [35:0] exp;
    start_op(32'hDEADBEEF, 32'h00001234, 32'h0, 1'b0, 4'b0011);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({Busy, Done, Result, MulFlags} !== 38'd0)
      $display("FAIL abort_clear got busy=%b done=%b res=%h flags=%b want all 0",
               Busy, Done, Result, MulFlags);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    seen_done = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (Done || Busy) seen_done++;
    end
    total++;
    if (seen_done !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", seen_done);
    else passed++;
    exp = model(32'h0000BEEF, 32'h00000101, 32'h00000003, 1'b1, 4'b0010);
    start_op(32'h0000BEEF, 32'h00000101, 32'h00000003, 1'b1, 4'b0010);
    run_to_done(-1, lat, bn, held);
    total++;
    if (Result !== exp[31:0] || MulFlags !== exp[35:32] || lat !== 33)
      $display("FAIL abort_restart got res=%h flags=%b lat=%0d want res=%h flags=%b lat=33",
               Result, MulFlags, lat, exp[31:0], exp[35:32]);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, bn;
    logic held;
    start_op(32'd3, 32'd5, 32'd0, 1'b0, 4'b0000);
    run_to_done(-1, lat1, bn, held);
    total++;
    if (Result !== 32'd15 || lat1 !== 33)
      $display("FAIL b2b_first got res=%h lat=%0d want res=0000000f lat=33", Result, lat1);
    else passed++;
    start_op(32'd9, 32'd9, 32'd0, 1'b0, 4'b0000);
    total++;
    if (Busy !== 1'b1 || Done !== 1'b0)
      $display("FAIL b2b_no_gap got busy=%b done=%b want 1 0", Busy, Done);
    else passed++;
    run_to_done(-1, lat2, bn, held);
    total++;
    if (Result !== 32'd81 || lat1 + lat2 !== 66)
      $display("FAIL b2b_second got res=%h at edge %0d want res=00000051 at edge 66",
               Result, lat1 + lat2);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_directed;
    test_random;
    test_start_ignored;
    test_reset_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
